// File: rtl/resource_arb_pkg.sv
// Shared types and defaults for the round-robin resource arbiter.
package resource_arb_pkg;

    localparam int unsigned DEF_NUM_REQ = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Index width for a pointer over n requesters, never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resource_arbiter_if.sv
// Request/resource/response bundle between the pipelines, the arbiter and the shared resource.
interface resource_arbiter_if
    import resource_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [DATA_W-1:0]         res_in_data;
    logic                      res_in_valid;
    logic [DATA_W-1:0]         res_out_data;
    logic                      res_out_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic                      busy;
    logic                      timeout_err;

    // Arbiter side.
    modport slave (
        input  req, req_valid, req_data, res_out_data, res_out_valid,
        output grant, res_in_data, res_in_valid, rsp_data, rsp_valid, busy, timeout_err
    );

    // Pipelines plus resource side.
    modport master (
        output req, req_valid, req_data, res_out_data, res_out_valid,
        input  grant, res_in_data, res_in_valid, rsp_data, rsp_valid, busy, timeout_err
    );

endinterface

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first candidate found scanning from ptr+1 upward, wrapping.
module rr_picker
    import resource_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_cand,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_found
);

    int unsigned w_idx;

    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = 32'(i_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!o_found && i_cand[PTR_W'(w_idx)]) begin
                o_found  = 1'b1;
                o_winner = PTR_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/resource_arbiter.sv
// Shares one single-outstanding resource among NUM_REQ pipelines: round-robin grant,
// one-shot issue, watchdog-bounded wait, response routed back to the owner.
module resource_arbiter
    import resource_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    resource_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = ptr_w(NUM_REQ);
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    arb_state_e          r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_res_in_valid;
    logic [DATA_W-1:0]   r_res_in_data;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_busy;
    logic                r_timeout_err;
    logic [WD_W-1:0]     r_wd;

    logic [NUM_REQ-1:0]  w_cand;
    logic [PTR_W-1:0]    w_winner;
    logic                w_found;
    logic                w_owner_valid;
    logic [DATA_W-1:0]   w_owner_data;

    assign w_cand = bus.req & bus.req_valid;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_cand   (w_cand),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // Select the current owner's valid and request word.
    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_owner == PTR_W'(i)) begin
                w_owner_valid = bus.req_valid[i];
                w_owner_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_ptr          <= PTR_W'(NUM_REQ - 1);
            r_owner        <= '0;
            r_grant        <= '0;
            r_res_in_valid <= 1'b0;
            r_res_in_data  <= '0;
            r_rsp_valid    <= '0;
            r_rsp_data     <= '0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_wd           <= '0;
        end else begin
            r_grant        <= '0;
            r_res_in_valid <= 1'b0;
            r_rsp_valid    <= '0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_owner <= w_winner;
                        r_ptr   <= w_winner;
                        r_grant <= NUM_REQ'(1) << w_winner;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    // A flushed owner releases the resource without issuing.
                    if (w_owner_valid) begin
                        r_res_in_data  <= w_owner_data;
                        r_res_in_valid <= 1'b1;
                        r_wd           <= '0;
                        r_state        <= WAIT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WAIT: begin
                    // A response on the expiry cycle takes priority over the watchdog.
                    if (bus.res_out_valid) begin
                        r_rsp_data  <= bus.res_out_data;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.res_in_data  = r_res_in_data;
    assign bus.res_in_valid = r_res_in_valid;
    assign bus.rsp_data     = r_rsp_data;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.busy         = r_busy;
    assign bus.timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_resource_arbiter.sv
// Self-checking bench for resource_arbiter: directed corner cases, a vector table and
// randomized transactions checked against a transaction-level round-robin model.
module tb_resource_arbiter;
    import resource_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk;
    logic reset;

    resource_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    resource_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: last granted index, sticky error, last delivered response.
    int            m_ptr;
    bit            m_terr;
    logic [DW-1:0] m_rsp;
    logic [DW-1:0] words [NR];

    typedef struct {
        logic [NR-1:0] rq;
        logic [NR-1:0] rv;
        bit            flush;
        int            dly;
        logic [DW-1:0] add;
        int            exp_owner;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_pick(input logic [NR-1:0] cand);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic rand_words();
        for (int i = 0; i < NR; i++) words[i] = $urandom;
    endtask

    task automatic drive_words();
        for (int i = 0; i < NR; i++) bus.req_data[i*DW +: DW] = words[i];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_res_in_valid", bus.res_in_valid, 0);
        chk("rst_res_in_data", bus.res_in_data, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        tick();
        reset  = 1'b0;
        m_ptr  = NR - 1;
        m_terr = 1'b0;
        m_rsp  = '0;
    endtask

    // One transaction from the IDLE state; response arrives dly cycles after the issue cycle.
    task automatic do_txn(input logic [NR-1:0] rq, input logic [NR-1:0] rv, input bit flush,
                          input int dly, input logic [DW-1:0] add, input int exp_owner);
        logic [NR-1:0] oh;
        logic [DW-1:0] exp_rsp;
        drive_words();
        bus.req       = rq;
        bus.req_valid = rv;
        tick();
        if (exp_owner < 0) begin
            chk("idle_grant", bus.grant, 0);
            chk("idle_busy", bus.busy, 0);
            bus.req = '0; bus.req_valid = '0;
            return;
        end
        oh    = NR'(1) << exp_owner;
        m_ptr = exp_owner;
        chk("grant", bus.grant, oh);
        chk("grant_busy", bus.busy, 1);
        if (flush) begin
            bus.req_valid[exp_owner] = 1'b0;
            tick();
            bus.req = '0; bus.req_valid = '0;
            chk("flush_issue", bus.res_in_valid, 0);
            chk("flush_busy", bus.busy, 0);
            chk("flush_grant_pulse", bus.grant, 0);
            tick();
            chk("flush_rsp", bus.rsp_valid, 0);
            return;
        end
        tick();
        bus.req = '0; bus.req_valid = '0;
        chk("issue_valid", bus.res_in_valid, 1);
        chk("issue_data", bus.res_in_data, words[exp_owner]);
        chk("grant_pulse", bus.grant, 0);
        exp_rsp = words[exp_owner] + add;
        for (int k = 0; k < TO; k++) begin
            if (k == dly) begin
                bus.res_out_valid = 1'b1;
                bus.res_out_data  = exp_rsp;
            end
            tick();
            bus.res_out_valid = 1'b0;
            if (k == dly) begin
                m_rsp = exp_rsp;
                chk("rsp_valid", bus.rsp_valid, oh);
                chk("rsp_data", bus.rsp_data, exp_rsp);
                chk("rsp_busy", bus.busy, 0);
                chk("rsp_terr", bus.timeout_err, m_terr);
                tick();
                chk("rsp_pulse", bus.rsp_valid, 0);
                return;
            end
            if (k == TO - 1) begin
                m_terr = 1'b1;
                chk("to_err", bus.timeout_err, 1);
                chk("to_busy", bus.busy, 0);
                chk("to_no_rsp", bus.rsp_valid, 0);
                bus.res_out_valid = 1'b1;
                bus.res_out_data  = ~exp_rsp;
                tick();
                bus.res_out_valid = 1'b0;
                chk("late_rsp_valid", bus.rsp_valid, 0);
                chk("late_rsp_data", bus.rsp_data, m_rsp);
                return;
            end
            chk("wait_busy", bus.busy, 1);
            chk("wait_terr", bus.timeout_err, m_terr);
            chk("wait_issue_once", bus.res_in_valid, 0);
        end
    endtask

    initial begin
        int order[$];
        int times[$];
        int exp_order[5];
        logic [NR-1:0] rq, rv;

        reset = 1'b0;
        bus.req = '0; bus.req_valid = '0; bus.req_data = '0;
        bus.res_out_valid = 1'b0; bus.res_out_data = '0;
        m_ptr = NR - 1; m_terr = 1'b0; m_rsp = '0;
        #3;
        do_reset();

        // Single requester, resource echoes +1 one cycle after the issue strobe.
        rand_words();
        words[2] = 32'hDEADBEEF;
        do_txn(4'b0100, 4'b0100, 1'b0, 1, 32'd1, 2);
        chk("single_rsp_const", bus.rsp_data, 32'hDEADBEF0);

        // Fairness: everyone requests continuously, resource answers on the issue cycle.
        do_reset();
        rand_words();
        drive_words();
        bus.req = '1; bus.req_valid = '1;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick();
            bus.res_out_valid = bus.res_in_valid;
            bus.res_out_data  = bus.res_in_data;
            for (int i = 0; i < NR; i++) begin
                if (bus.grant[i]) begin
                    order.push_back(i);
                    times.push_back(c);
                end
            end
        end
        bus.req = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.res_out_valid = bus.res_in_valid;
            bus.res_out_data  = bus.res_in_data;
        end
        bus.res_out_valid = 1'b0;
        bus.req_valid = '0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("fair_count", 64'(order.size()), 5);
        for (int i = 0; i < order.size() && i < 5; i++) chk("fair_order", 64'(order[i]), 64'(exp_order[i]));
        for (int i = 1; i < times.size(); i++) chk("fair_gap", 64'(times[i] - times[i-1]), 3);
        chk("fair_idle", bus.busy, 0);

        // Flush during grant keeps the pointer at the flushed owner.
        do_reset();
        rand_words();
        do_txn(4'b0110, 4'b0110, 1'b1, 0, 32'd0, 1);
        rand_words();
        do_txn(4'b0111, 4'b0111, 1'b0, 0, 32'd3, 2);

        // Response coinciding with watchdog expiry wins.
        rand_words();
        do_txn(4'b0001, 4'b0001, 1'b0, TO - 1, 32'd7, 0);
        chk("coincide_terr", bus.timeout_err, 0);

        // Silent resource: watchdog expiry, then late response ignored.
        rand_words();
        do_txn(4'b1000, 4'b1000, 1'b0, TO + 5, 32'd0, 3);

        // Reset in the first WAIT cycle aborts the transaction.
        rand_words();
        drive_words();
        bus.req = 4'b0010; bus.req_valid = 4'b0010;
        tick();
        chk("midrst_grant_pre", bus.grant, 4'b0010);
        tick();
        chk("midrst_issue_pre", bus.res_in_valid, 1);
        bus.req = '0; bus.req_valid = '0;
        bus.res_out_valid = 1'b1;
        bus.res_out_data  = 32'hA5A5_0001;
        do_reset();
        tick();
        bus.res_out_valid = 1'b0;
        chk("midrst_late_rsp", bus.rsp_valid, 0);
        chk("midrst_busy", bus.busy, 0);
        rand_words();
        do_txn(4'b1111, 4'b1111, 1'b0, 0, 32'd9, 0);

        // Vector table applied from a fresh reset.
        vecs[0] = '{4'b0101 << 1, 4'b1110, 1'b0, 2,      32'd5,  1};
        vecs[1] = '{4'b1111,      4'b1001, 1'b0, 0,      32'd6,  3};
        vecs[2] = '{4'b0000,      4'b1111, 1'b0, 0,      32'd0, -1};
        vecs[3] = '{4'b0111,      4'b0111, 1'b0, 4,      32'd8,  0};
        vecs[4] = '{4'b1000,      4'b1000, 1'b1, 0,      32'd0,  3};
        vecs[5] = '{4'b1100,      4'b1100, 1'b0, 1,      32'd2,  2};
        vecs[6] = '{4'b0011,      4'b0010, 1'b0, TO - 2, 32'd4,  1};
        vecs[7] = '{4'b1011,      4'b1011, 1'b0, 3,      32'd1,  3};
        do_reset();
        for (int v = 0; v < 8; v++) begin
            rand_words();
            do_txn(vecs[v].rq, vecs[v].rv, vecs[v].flush, vecs[v].dly, vecs[v].add, vecs[v].exp_owner);
        end

        // Randomized transactions against the model.
        for (int t = 0; t < 60; t++) begin
            rand_words();
            rq = NR'($urandom);
            rv = NR'($urandom);
            do_txn(rq, rv, ($urandom_range(0, 4) == 0), int'($urandom_range(0, TO + 2)),
                   DW'($urandom), model_pick(rq & rv));
        end
        chk("final_terr", bus.timeout_err, m_terr);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/resource_arbiter.md
# resource_arbiter

Shares one single-outstanding resource among NUM_REQ pipeline instances. Sits directly downstream of each pipeline's final stage and consumes its resource request (valid + data) through a registered one-hot grant. It forwards the winning word to the resource and waits for the response with a watchdog. It then returns the response to the owning pipeline.

## Interface
- NUM_REQ, 4, number of requesting pipelines (≥2)
- DATA_W, 32, request/response data width
- TIMEOUT, 64, max cycles waited for resource response (≥1)

- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high; all state cleared immediately
- req  input  NUM_REQ  per-pipeline arbiter request (eligibility)
- req_valid  input  NUM_REQ  per-pipeline valid-to-resource
- req_data  input  NUM_REQ*DATA_W  packed request words; requester i at [i*DATA_W +: DATA_W]
- grant  output  NUM_REQ  one-hot registered grant; final-stage stall = ~grant[i]
- res_in_data  output  DATA_W  word issued to resource
- res_in_valid  output  1  one-cycle issue strobe
- res_out_data  input  DATA_W  resource result
- res_out_valid  input  1  resource result strobe
- rsp_data  output  DATA_W  registered result, broadcast to all requesters
- rsp_valid  output  NUM_REQ  one-hot, one-cycle; marks owner of rsp_data
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  sticky; set on watchdog expiry, cleared only by reset

## Operation
- FSM states: IDLE, GRANT, WAIT.
- IDLE
  - Candidates are requesters i with req[i] & req_valid[i].
  - Round-robin pick starts at ptr+1 and wraps modulo NUM_REQ.
  - With a candidate: owner<=winner, ptr<=winner, go to GRANT.
  - With none: stay in IDLE.
- GRANT
  - grant[owner]=1 for exactly one cycle.
  - If req_valid[owner] is high at the clock edge: capture req_data[owner] into res_in_data, assert res_in_valid next cycle, clear watchdog, go to WAIT.
  - If req_valid[owner] is low (flushed): go to IDLE with no issue and no response; ptr is kept.
- WAIT
  - res_in_valid is high only on the first WAIT cycle.
  - Watchdog increments each cycle.
  - On res_out_valid: rsp_data<=res_out_data, rsp_valid[owner]<=1 for one cycle, go to IDLE.
  - If watchdog reaches TIMEOUT first: timeout_err<=1, go to IDLE, no rsp_valid.
  - If res_out_valid and watchdog expiry coincide: the response wins; no error is flagged.
- res_out_valid outside WAIT is ignored.
- Requests only stall while waiting; a requester is never dropped.
- Reset values: state IDLE, ptr=NUM_REQ-1 (requester 0 first after reset), grant=0, res_in_valid=0, res_in_data=0, rsp_valid=0, rsp_data=0, busy=0, timeout_err=0, watchdog=0.

## Timing
- Cycle 0: candidate seen in IDLE.
- Cycle 1: grant high.
- Cycle 2: res_in_valid high; a response in this same cycle is accepted.
- Minimum request-to-rsp_valid latency: 3 cycles, with rsp_valid in cycle 3.
- rsp_valid cycle is IDLE and may arbitrate, so back-to-back grants are 3 cycles apart.
- All outputs are registered; no combinational input-to-output path.
- Watchdog width is clog2(TIMEOUT+1). Expiry is at TIMEOUT WAIT cycles counted from the first WAIT cycle.
- Reset asserted mid-transaction aborts it: grant and res_in_valid drop asynchronously, and a later res_out_valid is ignored.

## Structure
- Shared package resource_arb_pkg: state enum (IDLE, GRANT, WAIT) and default parameter constants.
- One sub-module, rr_picker: combinational rotate-priority encoder (candidates, ptr → winner index, found).
- FSM, data registers and watchdog live in resource_arbiter.

## Test plan
- Single requester
  - Stimulus: req[2]=req_valid[2]=1, data 0xDEADBEEF; resource echoes +1 in the cycle after the issue strobe.
  - Required: grant=0b0100 in cycle 1, res_in_data=0xDEADBEEF in cycle 2, rsp_valid=0b0100 with rsp_data=0xDEADBEF0 in cycle 4.
- Fairness
  - Stimulus: all 4 requesters request continuously after reset.
  - Required: grant order 0,1,2,3,0; no requester granted twice before all others are granted once.
- Flush during grant
  - Stimulus: req_valid[1] drops in the GRANT cycle.
  - Required: no res_in_valid, no rsp_valid, back to IDLE; the next grant goes to requester 2 when it is pending.
- Timeout
  - Stimulus: TIMEOUT=8 with the resource silent.
  - Required: timeout_err rises 8 cycles after the first WAIT cycle, busy falls, and a late res_out_valid is ignored.
- Reset mid-WAIT
  - Stimulus: assert reset during WAIT.
  - Required: all outputs 0 immediately; the first grant after reset goes to requester 0.
- Coincident response and expiry
  - Stimulus: res_out_valid lands on the expiry cycle.
  - Required: rsp_valid asserted, timeout_err stays 0.
